// File: rtl/io_fifo_host.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo_host
// Description : Host-side command driver for the accelerator pad interface.
//               LOAD streams words into the chip in_fifo, START pulses
//               fsm_start and waits for a synchronised fsm_done edge (with
//               optional timeout), READ pulses send_best_arr and drains the
//               chip out_fifo into a registered rx stream.
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo_host #(
    parameter int DATA_W  = 11,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              in_fifo_wenq_o,
    output logic [DATA_W-1:0] in_fifo_wdata_o,
    input  logic              in_fifo_wfull_n_i,
    output logic              out_fifo_deq_o,
    input  logic [DATA_W-1:0] out_fifo_rdata_i,
    input  logic              out_fifo_rempty_n_i,
    output logic              load_kdtree_o,
    output logic              fsm_start_o,
    output logic              send_best_arr_o,
    input  logic              fsm_done_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PULSE     = 3'd1;
    localparam logic [2:0] S_XFER_TX   = 3'd2;
    localparam logic [2:0] S_XFER_RX   = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    // Counter only needs to reach TIMEOUT-1; TIMEOUT of 0 disables the check.
    localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    logic [2:0]        state_q, state_d;
    logic [1:0]        op_q;
    logic [LEN_W-1:0]  rem_q;
    logic              err_q;
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              load_q, start_q, send_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        sync_q;

    logic w_accept, w_rem_nz, w_rem_last, w_push, w_pop, w_done_edge, w_timeout;

    assign w_accept    = cmd_valid_i & (state_q == S_IDLE);
    assign w_rem_nz    = (rem_q != '0);
    assign w_rem_last  = (rem_q == LEN_W'(1));
    assign w_push      = (state_q == S_XFER_TX) & tx_valid_i & in_fifo_wfull_n_i & w_rem_nz;
    assign w_pop       = (state_q == S_XFER_RX) & out_fifo_rempty_n_i & w_rem_nz
                         & (~rx_valid_q | rx_ready_i);
    // sync_q[1] is the second synchroniser flop, sync_q[2] its delayed copy.
    assign w_done_edge = sync_q[1] & ~sync_q[2];
    assign w_timeout   = TIMEOUT_EN && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (cmd_valid_i && (cmd_op_i != OP_RSVD)) state_d = S_PULSE;
            S_PULSE: begin
                case (op_q)
                    OP_LOAD:  state_d = w_rem_nz ? S_XFER_TX : S_IDLE;
                    OP_READ:  state_d = w_rem_nz ? S_XFER_RX : S_IDLE;
                    OP_START: state_d = S_WAIT_DONE;
                    default:  state_d = S_IDLE;
                endcase
            end
            S_XFER_TX:   if (!w_rem_nz || (w_push && w_rem_last)) state_d = S_IDLE;
            S_XFER_RX:   if (!w_rem_nz || (w_pop && w_rem_last))  state_d = S_IDLE;
            S_WAIT_DONE: if (w_done_edge || w_timeout)            state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output decode; strobes are combinational so reset drops them at once
    always_comb begin
        cmd_ready_o     = (state_q == S_IDLE);
        busy_o          = (state_q != S_IDLE);
        tx_ready_o      = w_push;
        in_fifo_wenq_o  = w_push;
        in_fifo_wdata_o = tx_data_i;
        out_fifo_deq_o  = w_pop;
    end

    // Command latch, remaining-word count and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_LOAD;
            rem_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (w_accept) begin
                op_q  <= cmd_op_i;
                rem_q <= cmd_len_i;
                err_q <= (cmd_op_i == OP_RSVD);
            end else begin
                if (w_push || w_pop) rem_q <= rem_q - LEN_W'(1);
                if ((state_q == S_WAIT_DONE) && !w_done_edge && w_timeout) err_q <= 1'b1;
            end
        end
    end

    // One-cycle command pulses, high exactly during the PULSE state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q  <= 1'b0;
            start_q <= 1'b0;
            send_q  <= 1'b0;
        end else begin
            load_q  <= w_accept && (cmd_op_i == OP_LOAD);
            start_q <= w_accept && (cmd_op_i == OP_START);
            send_q  <= w_accept && (cmd_op_i == OP_READ);
        end
    end

    // Registered rx stream; a pop in the same cycle as rx_ready refills it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else if (w_pop) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= out_fifo_rdata_i;
        end else if (rx_ready_i) begin
            rx_valid_q <= 1'b0;
        end
    end

    // WAIT_DONE cycle counter, restarted from 0 on every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       cnt_q <= '0;
        else if (state_q == S_PULSE)      cnt_q <= '0;
        else if (state_q == S_WAIT_DONE)  cnt_q <= cnt_q + CNT_W'(1);
    end

    // fsm_done synchroniser plus delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 3'b000;
        else        sync_q <= {sync_q[1:0], fsm_done_i};
    end

    assign rx_valid_o      = rx_valid_q;
    assign rx_data_o       = rx_data_q;
    assign load_kdtree_o   = load_q;
    assign fsm_start_o     = start_q;
    assign send_best_arr_o = send_q;
    assign err_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_io_fifo_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_fifo_host
// Description : Self-checking bench for io_fifo_host: reset values, a table of
//               directed commands, randomized commands against a queue model
//               of the chip FIFOs, timeout on a short-TIMEOUT instance and an
//               asynchronous reset in the middle of a READ.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_fifo_host;
    localparam int DW  = 11;
    localparam int LW  = 16;
    localparam int TO  = 40;
    localparam int TO2 = 8;
    localparam logic [1:0] LOAD = 2'd0, START = 2'd1, READ = 2'd2, RSVD = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [LW-1:0] cmd_len = '0;
    logic          tx_valid, tx_ready, rx_valid, rx_ready = 1'b1;
    logic [DW-1:0] tx_data, rx_data, wdata, rdata;
    logic          wenq, wfull_n = 1'b1, deq, rempty_n;
    logic          load_p, start_p, send_p, fsm_done = 1'b0, busy, err;

    // Environment: tx source, chip out_fifo contents, captured traffic
    logic [DW-1:0] tx_mem [1024];
    int            tx_n = 0, tx_idx = 0;
    logic          tx_gate = 1'b1;
    logic [DW-1:0] oq_mem [256];
    int            oq_head = 0, oq_tail = 0;
    logic          oq_stall = 1'b0;
    logic [DW-1:0] pushed_mem [1024];
    logic [DW-1:0] got_mem [1024];
    int            push_cnt = 0, got_cnt = 0;
    int            n_load = 0, n_start = 0, n_send = 0, n_busy = 0;
    logic [DW-1:0] mq [$];
    int            n_chk = 0, n_err = 0;

    assign tx_valid = (tx_idx < tx_n) && tx_gate;
    assign tx_data  = tx_mem[tx_idx % 1024];
    assign rempty_n = (oq_head != oq_tail) && !oq_stall;
    assign rdata    = oq_mem[oq_head % 256];

    io_fifo_host #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_len_i(cmd_len),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data),
        .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_data_o(rx_data),
        .in_fifo_wenq_o(wenq), .in_fifo_wdata_o(wdata), .in_fifo_wfull_n_i(wfull_n),
        .out_fifo_deq_o(deq), .out_fifo_rdata_i(rdata), .out_fifo_rempty_n_i(rempty_n),
        .load_kdtree_o(load_p), .fsm_start_o(start_p), .send_best_arr_o(send_p),
        .fsm_done_i(fsm_done), .busy_o(busy), .err_o(err)
    );

    // Second instance with a short timeout; only its command port is exercised
    logic          c2_valid = 1'b0, t2_cmd_ready, t2_tx_ready, t2_rx_valid, t2_wenq, t2_deq;
    logic [1:0]    c2_op = 2'd0;
    logic [DW-1:0] t2_rx_data, t2_wdata;
    logic          t2_load, t2_start, t2_send, t2_busy, t2_err;

    io_fifo_host #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO2)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(c2_valid), .cmd_ready_o(t2_cmd_ready), .cmd_op_i(c2_op), .cmd_len_i(16'd0),
        .tx_valid_i(1'b0), .tx_ready_o(t2_tx_ready), .tx_data_i(11'd0),
        .rx_valid_o(t2_rx_valid), .rx_ready_i(1'b1), .rx_data_o(t2_rx_data),
        .in_fifo_wenq_o(t2_wenq), .in_fifo_wdata_o(t2_wdata), .in_fifo_wfull_n_i(1'b1),
        .out_fifo_deq_o(t2_deq), .out_fifo_rdata_i(11'd0), .out_fifo_rempty_n_i(1'b0),
        .load_kdtree_o(t2_load), .fsm_start_o(t2_start), .send_best_arr_o(t2_send),
        .fsm_done_i(1'b0), .busy_o(t2_busy), .err_o(t2_err)
    );

    // Capture every handshake and pulse seen on the clock edge
    always @(posedge clk) begin
        if (wenq) begin
            pushed_mem[push_cnt % 1024] <= wdata;
            push_cnt <= push_cnt + 1;
        end
        if (tx_valid && tx_ready) tx_idx <= tx_idx + 1;
        if (deq) oq_head <= oq_head + 1;
        if (rx_valid && rx_ready) begin
            got_mem[got_cnt % 1024] <= rx_data;
            got_cnt <= got_cnt + 1;
        end
        if (load_p)  n_load  <= n_load + 1;
        if (start_p) n_start <= n_start + 1;
        if (send_p)  n_send  <= n_send + 1;
        if (busy)    n_busy  <= n_busy + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic check_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic logic [DW-1:0] pword(input int pre, input int i);
        logic [DW-1:0] t;
        if (pre == 1) t = DW'(i + 1);
        else begin
            case (i)
                0:       t = 11'h7FF;
                1:       t = 11'h000;
                2:       t = 11'h155;
                3:       t = 11'h2AA;
                default: t = 11'h003;
            endcase
        end
        return t;
    endfunction

    task automatic add_oq(input logic [DW-1:0] w);
        oq_mem[oq_tail % 256] = w;
        oq_tail++;
        mq.push_back(w);
    endtask

    // mode: 0 clean, 1 random stalls, 2 wfull_n low 5 cycles, 3 rx_ready toggling
    task automatic run_cmd(input logic [1:0] op, input int len, input int dly, input int mode,
                           input int pre, input int bmin, input int bmax,
                           input bit e_err, input logic [2:0] e_pulse);
        int p0, g0, h0, l0, s0, r0, b0, cyc, k;
        logic [DW-1:0] ew[$];
        logic [DW-1:0] w;
        if (op == LOAD)
            for (int i = 0; i < len; i++) begin
                w = (pre != 0) ? pword(pre, i) : DW'($urandom);
                ew.push_back(w);
                tx_mem[tx_n % 1024] = w;
                tx_n++;
            end
        if (op == READ) begin
            for (int i = 0; i < len; i++) add_oq((pre != 0) ? pword(pre, i) : DW'($urandom));
            k = (mode == 1) ? int'($urandom_range(0, 2)) : 0;
            for (int i = 0; i < k; i++) add_oq(DW'($urandom));
        end
        if (dly == -2) begin
            fsm_done = 1'b1;
            repeat (4) @(negedge clk);
        end
        p0 = push_cnt; g0 = got_cnt; h0 = oq_head;
        l0 = n_load; s0 = n_start; r0 = n_send; b0 = n_busy;
        check("cmd_ready before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = LW'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 300) begin
            case (mode)
                1: begin
                    tx_gate  = ($urandom % 4) != 0;
                    wfull_n  = ($urandom % 4) != 0;
                    oq_stall = ($urandom % 4) == 0;
                    rx_ready = ($urandom % 2) != 0;
                end
                2:       wfull_n = !(cyc >= 2 && cyc < 7);
                3:       rx_ready = cyc[0];
                default: ;
            endcase
            if (op == START && dly >= 0 && cyc == dly) fsm_done = 1'b1;
            @(negedge clk);
            if (mode == 2 && !wfull_n) check("no wenq while full", wenq, 0);
            cyc++;
        end
        check("cmd completes", busy, 0);
        tx_gate = 1'b1; wfull_n = 1'b1; oq_stall = 1'b0; rx_ready = 1'b1;
        cyc = 0;
        while (rx_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rx drained", rx_valid, 0);
        fsm_done = 1'b0;
        repeat (4) @(negedge clk);
        check_rng("busy cycles", n_busy - b0, bmin, bmax);
        check("load pulses", n_load - l0, int'(e_pulse[0]));
        check("start pulses", n_start - s0, int'(e_pulse[1]));
        check("send pulses", n_send - r0, int'(e_pulse[2]));
        check("err", err, int'(e_err));
        check("cmd_ready after", cmd_ready, 1);
        check("push count", push_cnt - p0, (op == LOAD) ? len : 0);
        check("deq count", oq_head - h0, (op == READ) ? len : 0);
        check("rx count", got_cnt - g0, (op == READ) ? len : 0);
        if (op == LOAD)
            for (int i = 0; i < len; i++)
                check("push data", pushed_mem[(p0 + i) % 1024], ew[i]);
        if (op == READ)
            for (int i = 0; i < len; i++) begin
                w = mq.pop_front();
                check("rx data", got_mem[(g0 + i) % 1024], w);
            end
    endtask

    typedef struct {
        logic [1:0] op;
        int         len;
        int         dly;
        int         mode;
        int         pre;
        int         bmin;
        int         bmax;
        bit         e_err;
        logic [2:0] e_pulse;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, len, dly, bmin, bmax;
        logic [1:0] op;

        tbl[0]  = '{LOAD,  4,  0, 0, 1,  5,  5, 1'b0, 3'b001};
        tbl[1]  = '{LOAD,  3,  0, 2, 0,  9,  9, 1'b0, 3'b001};
        tbl[2]  = '{READ,  5,  0, 3, 2,  6, 20, 1'b0, 3'b100};
        tbl[3]  = '{READ,  0,  0, 0, 0,  1,  1, 1'b0, 3'b100};
        tbl[4]  = '{RSVD,  0,  0, 0, 0,  0,  0, 1'b1, 3'b000};
        tbl[5]  = '{LOAD,  0,  0, 0, 0,  1,  1, 1'b0, 3'b001};
        tbl[6]  = '{START, 0, 20, 0, 0, 22, 24, 1'b0, 3'b010};
        tbl[7]  = '{START, 0, -1, 0, 0, 41, 41, 1'b1, 3'b010};
        tbl[8]  = '{START, 0, -2, 0, 0, 41, 41, 1'b1, 3'b010};
        tbl[9]  = '{READ,  4,  0, 0, 0,  5,  5, 1'b0, 3'b100};
        tbl[10] = '{START, 0,  7, 0, 0,  9, 11, 1'b0, 3'b010};
        tbl[11] = '{RSVD,  5,  0, 0, 0,  0,  0, 1'b1, 3'b000};
        tbl[12] = '{LOAD,  1,  0, 0, 0,  2,  2, 1'b0, 3'b001};

        // Reset values while rst_n is held low
        @(negedge clk);
        check("rst cmd_ready", cmd_ready, 1);
        check("rst busy", busy, 0);
        check("rst err", err, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_data", rx_data, 0);
        check("rst strobes", {wenq, deq, tx_ready}, 0);
        check("rst pulses", {load_p, start_p, send_p}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i])
            run_cmd(tbl[i].op, tbl[i].len, tbl[i].dly, tbl[i].mode, tbl[i].pre,
                    tbl[i].bmin, tbl[i].bmax, tbl[i].e_err, tbl[i].e_pulse);

        // Randomized commands checked against the FIFO queue model
        for (int n = 0; n < 40; n++) begin
            op  = 2'($urandom % 4);
            len = int'($urandom % 7);
            dly = (($urandom % 8) == 0) ? -1 : int'($urandom_range(1, 25));
            if (op == RSVD)                 begin bmin = 0;       bmax = 0;       end
            else if (op == START && dly < 0) begin bmin = TO + 1;  bmax = TO + 1;  end
            else if (op == START)           begin bmin = dly + 2; bmax = dly + 4; end
            else                            begin bmin = len + 1; bmax = 1000;    end
            run_cmd(op, len, dly, 1, 0, bmin, bmax,
                    (op == RSVD) || (op == START && dly < 0),
                    (op == RSVD) ? 3'b000 : 3'(1 << op));
        end

        // Short-timeout instance: START with no done -> PULSE + TO2 wait cycles, err set
        check("t2 err before", t2_err, 0);
        c2_valid = 1'b1; c2_op = START;
        @(negedge clk);
        c2_valid = 1'b0;
        check("t2 start pulse", t2_start, 1);
        cyc = 0;
        while (t2_busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t2 busy cycles", cyc, TO2 + 1);
        check("t2 timeout err", t2_err, 1);
        check("t2 cmd_ready", t2_cmd_ready, 1);

        // Asynchronous reset in the middle of a READ
        for (int i = 0; i < 10; i++) add_oq(DW'($urandom));
        cmd_valid = 1'b1; cmd_op = READ; cmd_len = LW'(10);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid-read deq", deq, 1);
        check("mid-read rx_valid", rx_valid, 1);
        rst_n = 1'b0;
        #1;
        check("abort deq", deq, 0);
        check("abort wenq", wenq, 0);
        check("abort rx_valid", rx_valid, 0);
        check("abort busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset cmd_ready", cmd_ready, 1);
        check("post-reset rx_data", rx_data, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
